// File: rtl/clock_pkg.sv
// Shared types and constants for the clock page: set-FSM states, display digit codes,
// time limits and a wrap-around step helper.
package clock_pkg;

  typedef enum logic [1:0] {
    DISP     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } clk_state_e;

  localparam logic [3:0] DIG_BLANK = 4'hA;
  localparam logic [3:0] DIG_AM    = 4'hC;
  localparam logic [3:0] DIG_PM    = 4'hD;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  // One step up or down in the range 0..max_v, wrapping at both ends.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0)  ? max_v : v - 6'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_60.sv
// Combinational 0..59 binary to two-digit BCD converter, one instance per display field.
module bin2bcd_60 (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  always_comb begin
    tens = 4'(bin / 6'd10);
    ones = 4'(bin % 6'd10);
  end

endmodule

// File: rtl/multi_alarm_clock_core.sv
// Clock page core: live H:M:S, hour/minute set FSM, 24h/12h BCD display with blink and a
// NUM_ALARMS-channel latched alert. Define SNOOZE_EN to build the snooze re-arm logic.
module multi_alarm_clock_core
  import clock_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_1hz,
  input  logic                    blink,
  input  logic                    mode_active,
  input  logic                    pulsed_set,
  input  logic                    pulsed_up,
  input  logic                    pulsed_down,
  input  logic [5*NUM_ALARMS-1:0] alarm_hours,
  input  logic [6*NUM_ALARMS-1:0] alarm_minutes,
  input  logic [NUM_ALARMS-1:0]   alarm_enable,
  output logic [4:0]              cur_hours,
  output logic [5:0]              cur_minutes,
  output logic [5:0]              cur_seconds,
  output logic [23:0]             bcd_out,
  output logic                    hour12,
  output logic                    in_disp_state,
  output logic                    alarm_alert,
  output logic [AW-1:0]           alarm_source
);

  clk_state_e      state_q, state_d;
  logic [4:0]      hours_q, hours_d, stage_h_q, stage_h_d, tick_h;
  logic [5:0]      minutes_q, minutes_d, seconds_q, seconds_d, stage_m_q, stage_m_d;
  logic [5:0]      tick_m, tick_s;
  logic            hour12_q, hour12_d, alert_q, alert_d;
  logic [AW-1:0]   source_q, source_d, ch_idx;
  logic            commit, at_minute, ch_hit, up_snoozes, snz_fire;

  always_comb begin
    tick_s = seconds_q;
    tick_m = minutes_q;
    tick_h = hours_q;
    if (tick_1hz) begin
      tick_s = wrap_step(seconds_q, MAX_MIN, 1'b1);
      if (seconds_q == MAX_MIN) begin
        tick_m = wrap_step(minutes_q, MAX_MIN, 1'b1);
        if (minutes_q == MAX_MIN) tick_h = 5'(wrap_step({1'b0, hours_q}, {1'b0, MAX_HOUR}, 1'b1));
      end
    end
  end

  assign at_minute = tick_1hz && (tick_s == 6'd0);

  // Scan downwards so the lowest matching channel is the one left in ch_idx.
  always_comb begin
    ch_hit = 1'b0;
    ch_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (alarm_enable[k] && alarm_hours[5*k +: 5] == tick_h && alarm_minutes[6*k +: 6] == tick_m) begin
        ch_hit = 1'b1;
        ch_idx = AW'(k);
      end
    end
  end

`ifdef SNOOZE_EN
  logic            snz_armed_q, snz_armed_d;
  logic [4:0]      snz_h_q, snz_h_d, snz_h_tgt;
  logic [5:0]      snz_m_q, snz_m_d, snz_m_tgt;
  logic [6:0]      snz_msum;

  always_comb begin
    snz_msum  = {1'b0, minutes_q} + 7'(SNOOZE_MIN);
    snz_h_tgt = hours_q;
    snz_m_tgt = 6'(snz_msum);
    if (snz_msum > 7'd59) begin
      snz_m_tgt = 6'(snz_msum - 7'd60);
      snz_h_tgt = 5'(wrap_step({1'b0, hours_q}, {1'b0, MAX_HOUR}, 1'b1));
    end
  end

  assign up_snoozes = alert_q;
  assign snz_fire   = snz_armed_q && at_minute && tick_h == snz_h_q && tick_m == snz_m_q;
`else
  assign up_snoozes = 1'b0;
  assign snz_fire   = 1'b0;
`endif

  assign commit = mode_active && pulsed_set && (state_q == SET_MIN);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    hours_d   = tick_h;
    minutes_d = tick_m;
    seconds_d = tick_s;
    stage_h_d = stage_h_q;
    stage_m_d = stage_m_q;
    hour12_d  = hour12_q;
    alert_d   = alert_q;
    source_d  = source_q;
`ifdef SNOOZE_EN
    snz_armed_d = snz_armed_q;
    snz_h_d     = snz_h_q;
    snz_m_d     = snz_m_q;
`endif
    if (commit) begin
      hours_d   = stage_h_q;
      minutes_d = stage_m_q;
      seconds_d = 6'd0;
      alert_d   = 1'b0;
      state_d   = DISP;
`ifdef SNOOZE_EN
      snz_armed_d = 1'b0;
`endif
    end else begin
      if (mode_active) begin
        case (state_q)
          DISP: begin
            if (pulsed_set) begin
              state_d   = SET_HOUR;
              stage_h_d = hours_q;
              stage_m_d = minutes_q;
            end else if (pulsed_up) begin
              if (up_snoozes) begin
                alert_d = 1'b0;
`ifdef SNOOZE_EN
                snz_armed_d = 1'b1;
                snz_h_d     = snz_h_tgt;
                snz_m_d     = snz_m_tgt;
`endif
              end else begin
                hour12_d = ~hour12_q;
              end
            end else if (pulsed_down) begin
              alert_d = 1'b0;
`ifdef SNOOZE_EN
              snz_armed_d = 1'b0;
`endif
            end
          end
          SET_HOUR: begin
            if (pulsed_set)       state_d   = SET_MIN;
            else if (pulsed_up)   stage_h_d = 5'(wrap_step({1'b0, stage_h_q}, {1'b0, MAX_HOUR}, 1'b1));
            else if (pulsed_down) stage_h_d = 5'(wrap_step({1'b0, stage_h_q}, {1'b0, MAX_HOUR}, 1'b0));
          end
          SET_MIN: begin
            if (pulsed_up)        stage_m_d = wrap_step(stage_m_q, MAX_MIN, 1'b1);
            else if (pulsed_down) stage_m_d = wrap_step(stage_m_q, MAX_MIN, 1'b0);
          end
          default: state_d = DISP;
        endcase
      end
      // Alarm events are applied last so they win over a dismiss in the same cycle.
      if (snz_fire) begin
        alert_d = 1'b1;
`ifdef SNOOZE_EN
        snz_armed_d = 1'b0;
`endif
      end
      if (at_minute && ch_hit) begin
        alert_d = 1'b1;
        if (!alert_q) source_d = ch_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DISP;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      stage_h_q <= '0;
      stage_m_q <= '0;
      hour12_q  <= 1'b0;
      alert_q   <= 1'b0;
      source_q  <= '0;
`ifdef SNOOZE_EN
      snz_armed_q <= 1'b0;
      snz_h_q     <= '0;
      snz_m_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      state_q   <= state_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      stage_h_q <= stage_h_d;
      stage_m_q <= stage_m_d;
      hour12_q  <= hour12_d;
      alert_q   <= alert_d;
      source_q  <= source_d;
`ifdef SNOOZE_EN
      snz_armed_q <= snz_armed_d;
      snz_h_q     <= snz_h_d;
      snz_m_q     <= snz_m_d;
`endif
    end
  end

  // Display path: while editing, the staging h:m is shown with seconds forced to zero.
  logic       editing, blank_h, blank_m;
  logic [4:0] disp_h, h12_val, hour_field;
  logic [5:0] disp_m, disp_s;
  logic [3:0] h_t, h_o, m_t, m_o, s_t, s_o;
  logic [7:0] hh_dig, mm_dig;

  always_comb begin
    editing    = (state_q != DISP);
    disp_h     = editing ? stage_h_q : hours_q;
    disp_m     = editing ? stage_m_q : minutes_q;
    disp_s     = editing ? 6'd0 : seconds_q;
    h12_val    = (disp_h == 5'd0) ? 5'd12 : (disp_h > 5'd12) ? disp_h - 5'd12 : disp_h;
    hour_field = hour12_q ? h12_val : disp_h;
    blank_h    = (state_q == SET_HOUR) && !blink;
    blank_m    = (state_q == SET_MIN) && !blink;
    hh_dig     = blank_h ? {DIG_BLANK, DIG_BLANK} : {h_t, h_o};
    mm_dig     = blank_m ? {DIG_BLANK, DIG_BLANK} : {m_t, m_o};
    bcd_out    = hour12_q ? {(disp_h < 5'd12) ? DIG_AM : DIG_PM, DIG_BLANK, hh_dig, mm_dig}
                          : {hh_dig, mm_dig, s_t, s_o};
  end

  bin2bcd_60 u_hour_bcd (.bin({1'b0, hour_field}), .tens(h_t), .ones(h_o));
  bin2bcd_60 u_min_bcd  (.bin(disp_m),             .tens(m_t), .ones(m_o));
  bin2bcd_60 u_sec_bcd  (.bin(disp_s),             .tens(s_t), .ones(s_o));

  assign cur_hours     = hours_q;
  assign cur_minutes   = minutes_q;
  assign cur_seconds   = seconds_q;
  assign hour12        = hour12_q;
  assign in_disp_state = (state_q == DISP);
  assign alarm_alert   = alert_q;
  assign alarm_source  = source_q;

endmodule

// File: doc/multi_alarm_clock_core.md
Name: multi_alarm_clock_core

Overview:
- Parametrised timekeeping core for the mode-0 (clock) page of the watch design.
- Keeps the live H:M:S time, runs the hour/minute set FSM, and renders 24h or 12h BCD digits with blink.
- Watches NUM_ALARMS independent alarms and latches a single alert with the index of the alarm that fired.
- Takes a one-second tick enable from the divider instead of a second clock domain.

Parameters:
NUM_ALARMS, 4, number of alarm channels (1..8)
SNOOZE_MIN, 5, snooze delay in minutes (1..59; used only with SNOOZE_EN)
AW, $clog2(NUM_ALARMS) min 1, width of alarm_source (derived localparam)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-cycle pulse, once per second
blink  in  1  blink phase; 1 = digits visible
mode_active  in  1  high when the clock page is selected; gates all button actions
pulsed_set  in  1  one-cycle set button pulse
pulsed_up  in  1  one-cycle up button pulse
pulsed_down  in  1  one-cycle down button pulse
alarm_hours  in  5*NUM_ALARMS  packed alarm hours, channel k at [5k+4:5k]
alarm_minutes  in  6*NUM_ALARMS  packed alarm minutes
alarm_enable  in  NUM_ALARMS  per-channel arm bit
cur_hours  out  5  live hours 0..23
cur_minutes  out  6  live minutes
cur_seconds  out  6  live seconds
bcd_out  out  24  six BCD digits; [23:20] leftmost, [3:0] rightmost
hour12  out  1  0 = 24h display, 1 = 12h display
in_disp_state  out  1  FSM is in DISP
alarm_alert  out  1  alert latched
alarm_source  out  AW  channel that caused the current alert

Behaviour:
- Reset values:
  - time 00:00:00, FSM DISP, hour12=0, alarm_alert=0, alarm_source=0.
  - staging h/m = 0, snooze disarmed.
  - bcd_out=24'h000000, in_disp_state=1.
- Timekeeping:
  - On tick_1hz, seconds increment; 59 wraps to 0 and carries into minutes.
  - Minutes 59 wrap to 0 and carry into hours; hours 23 wrap to 0.
  - Time runs in every FSM state.
- Set FSM (DISP, SET_HOUR, SET_MIN). All transitions require mode_active.
  - DISP: pulsed_set moves to SET_HOUR and copies live h:m into the staging registers.
  - SET_HOUR: up/down add/subtract 1 to the staging hour, wrapping 23<->0. pulsed_set moves to SET_MIN.
  - SET_MIN: up/down adjust the staging minute, wrapping 59<->0. pulsed_set commits: time <= staging h:m, seconds <= 0, alarm_alert <= 0, snooze disarmed, return to DISP.
  - A commit overrides a tick in the same cycle.
  - Dropping mode_active mid-set freezes the FSM in its current state; it does not abort.
- Display (combinational from registers; zero latency):
  - 24h DISP: HH MM SS.
  - 24h set: HH MM 00. The field being edited shows 4'hA (blank) on both of its digits while blink=0.
  - 12h mode:
    - digit5 = 4'hC (AM) or 4'hD (PM); digit4 = 4'hA.
    - Digits 3..0 = hh mm, with hour 0 shown as 12 and 13..23 shown as hour-12.
    - 12h set blinks the hour or minute digits the same way as 24h set.
- Display mode: pulsed_up in DISP with mode_active toggles hour12 (subject to the snooze rule under Optional Feature).
- Alarms:
  - On a tick whose resulting time is hh:mm:00, every channel k with alarm_enable[k] and alarm h:m equal to hh:mm matches.
  - Any match sets alarm_alert=1, and alarm_source = lowest matching index.
  - A match while alarm_alert is already 1 is ignored; source is unchanged.
  - pulsed_down in DISP with mode_active clears alarm_alert; in DISP, down has no other function.
  - A match and a dismiss in the same cycle: the match wins and alert stays 1.
  - Asserting reset mid-alert clears everything to reset values.

Optional Feature:
SNOOZE_EN:
- Defined:
  - pulsed_up in DISP while alarm_alert=1 clears the alert instead of toggling hour12.
  - The snooze target is set to live h:m + SNOOZE_MIN, modulo 24h, and alarm_source is retained.
  - When a tick lands on target:00, the alert re-asserts with that source; the snooze disarms.
  - Dismiss (down), commit, and reset each disarm the snooze.
  - A snooze fire and a channel match in the same tick: the channel match wins for alarm_source.
- Undefined: no snooze registers exist, and pulsed_up always toggles hour12.

Decomposition:
- Shared package clock_pkg:
  - FSM state enum: DISP=0, SET_HOUR=1, SET_MIN=2.
  - Digit codes: DIG_BLANK=4'hA, DIG_AM=4'hC, DIG_PM=4'hD.
  - Constants: MAX_HOUR=23, MAX_MIN=59.
- Sub-module bin2bcd_60: 6-bit 0..59 to two BCD digits, purely combinational. Instantiated once per displayed field.

Test Plan:
- Rollover: reset, set 23:59 via set/up/down, commit, 60 ticks -> cur time 00:00:00 and bcd_out=24'h000000.
- Set blink: enter SET_HOUR with staging 09:00, blink=0 -> bcd_out[23:16]=8'hAA; blink=1 -> 8'h09. Press down at staging 0 -> staging hour becomes 23.
- Multi-alarm priority: channels 1 and 3 armed at 07:30, channel 0 disarmed at 07:30, time 07:29:59, one tick -> alarm_alert=1, alarm_source=1. A further match at 07:31 leaves alarm_source=1.
- Dismiss vs match: pulsed_down in the same cycle as a matching tick -> alarm_alert stays 1. Next pulsed_down -> 0.
- 12h render: time 00:05:00, pulsed_up -> hour12=1, bcd_out=24'hCA1205. At 13:45 -> 24'hDA0145.
- SNOOZE_EN with SNOOZE_MIN=5: alert at 06:00:00, pulsed_up at 06:00:10 -> alert=0, hour12 unchanged. Alert re-asserts on the tick reaching 06:05:00.
